mist_rom_sender: RTL and testbench

- Test-side transmitter for the MiST ROM download interface; it plays the role of the firmware/SPI side.
- Streams a ROM image byte by byte into the game core through the ioctl write port, framed by the downloading flag.
- On completion it drops downloading. That falling edge is the event the simulation dump and monitor logic keys on to start capture after the load.
- Synthesizable so it can also drive FPGA bring-up builds with a ROM image held in block RAM.

---
 rtl/mist_rom_sender.sv | 108 ++++++++++
 tb/tb_mist_rom_sender.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mist_rom_sender.sv
// Firmware-side ROM downloader for the MiST ioctl interface: streams ROM_LEN image
// bytes to the core framed by downloading, then pulses done as downloading falls.
module mist_rom_sender #(
    parameter int         AW        = 22,
    parameter int         ROM_LEN   = 1024,
    parameter int         START_DLY = 16,
    parameter int         WR_GAP    = 7,
    parameter logic [7:0] INDEX     = 8'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          hold,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic          downloading,
    output logic [7:0]    ioctl_index,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    output logic          ioctl_wr,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        FETCH,
        WRITE,
        GAP,
        FINISH
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_LEN - 1);
    localparam logic [15:0]   DLY_LOAD  = 16'(START_DLY - 1);
    localparam logic [7:0]    GAP_LOAD  = 8'(WR_GAP - 1);

    state_t      state;
    logic [15:0] dly_cnt;
    logic [7:0]  gap_cnt;

    // rom_addr doubles as the byte address of the transfer in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            dly_cnt     <= '0;
            gap_cnt     <= '0;
            rom_addr    <= '0;
            downloading <= 1'b0;
            ioctl_index <= 8'd0;
            ioctl_addr  <= '0;
            ioctl_dout  <= 8'd0;
            ioctl_wr    <= 1'b0;
            done        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every branch reads the
            // pre-edge register values and the defaults below are simply overridden.
            ioctl_wr <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                // FINISH samples start as well, so a held start leaves downloading
                // low for exactly the single FINISH cycle.
                IDLE, FINISH: begin
                    if (start) begin
                        state       <= DELAY;
                        downloading <= 1'b1;
                        ioctl_index <= INDEX;
                        dly_cnt     <= DLY_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                DELAY: begin
                    if (dly_cnt == '0) begin
                        state    <= FETCH;
                        rom_addr <= '0;
                    end else begin
                        dly_cnt <= dly_cnt - 16'd1;
                    end
                end
                FETCH: state <= WRITE;
                WRITE: begin
                    ioctl_wr   <= 1'b1;
                    ioctl_addr <= rom_addr;
                    ioctl_dout <= rom_data;
                    gap_cnt    <= GAP_LOAD;
                    state      <= GAP;
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end else if (!hold) begin
                        if (rom_addr == LAST_ADDR) begin
                            state       <= FINISH;
                            downloading <= 1'b0;
                            ioctl_index <= 8'd0;
                            done        <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + AW'(1);
                            state    <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mist_rom_sender.sv
// Self-checking bench for mist_rom_sender: two instances (wide/narrow address) checked
// against a timing model derived from the per-byte and hold rules.
module tb_mist_rom_sender;

    localparam int         AW_A  = 22;
    localparam int         LEN_A = 4;
    localparam int         DLY_A = 16;
    localparam int         GAP_A = 7;
    localparam logic [7:0] IDX_A = 8'h3c;
    localparam int         AW_B  = 3;
    localparam int         LEN_B = 8;
    localparam int         DLY_B = 4;
    localparam int         GAP_B = 1;
    localparam logic [7:0] IDX_B = 8'h05;
    localparam int         LOGN  = 8192;

    logic clk = 1'b0;
    logic rst_n;

    logic            start_a, hold_a, dl_a, wr_a, done_a;
    logic [AW_A-1:0] rom_addr_a, ia_a;
    logic [7:0]      rom_data_a, idx_a, id_a;
    logic            start_b, hold_b, dl_b, wr_b, done_b;
    logic [AW_B-1:0] rom_addr_b, ia_b;
    logic [7:0]      rom_data_b, idx_b, id_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] img_a [LEN_A];
    logic [7:0] img_b [LEN_B];
    bit         hold_log [LOGN];

    always #5 clk = ~clk;

    mist_rom_sender #(.AW(AW_A), .ROM_LEN(LEN_A), .START_DLY(DLY_A), .WR_GAP(GAP_A), .INDEX(IDX_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .hold(hold_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .downloading(dl_a),
        .ioctl_index(idx_a), .ioctl_addr(ia_a), .ioctl_dout(id_a),
        .ioctl_wr(wr_a), .done(done_a)
    );

    mist_rom_sender #(.AW(AW_B), .ROM_LEN(LEN_B), .START_DLY(DLY_B), .WR_GAP(GAP_B), .INDEX(IDX_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .hold(hold_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .downloading(dl_b),
        .ioctl_index(idx_b), .ioctl_addr(ia_b), .ioctl_dout(id_b),
        .ioctl_wr(wr_b), .done(done_b)
    );

    // Synchronous image memories: data valid one cycle after the address.
    always @(posedge clk) begin
        rom_data_a <= img_a[rom_addr_a[1:0]];
        rom_data_b <= img_b[rom_addr_b];
        hold_log[cyc % LOGN] <= hold_a;
        cyc <= cyc + 1;
    end

    int              wr_cyc_a[$];
    logic [AW_A-1:0] wr_addr_a[$];
    logic [7:0]      wr_dout_a[$];
    int              rise_a[$], fall_a[$], done_cyc_a[$];
    int              wr_cyc_b[$];
    logic [AW_B-1:0] wr_addr_b[$];
    logic [7:0]      wr_dout_b[$];
    int              rise_b[$], fall_b[$], done_cyc_b[$];
    int              idx_bad = 0, dbl_wr = 0, wr_idle = 0;
    logic            prev_wr_a = 1'b0, prev_dl_a = 1'b0, prev_wr_b = 1'b0, prev_dl_b = 1'b0;

    always @(negedge clk) begin
        if (wr_a === 1'b1) begin
            wr_cyc_a.push_back(cyc);
            wr_addr_a.push_back(ia_a);
            wr_dout_a.push_back(id_a);
        end
        if (dl_a === 1'b1 && prev_dl_a !== 1'b1) rise_a.push_back(cyc);
        if (dl_a === 1'b0 && prev_dl_a === 1'b1) fall_a.push_back(cyc);
        if (done_a === 1'b1) done_cyc_a.push_back(cyc);
        if (idx_a !== ((dl_a === 1'b1) ? IDX_A : 8'h00)) idx_bad++;
        if (wr_a === 1'b1 && prev_wr_a === 1'b1) dbl_wr++;
        if (wr_a === 1'b1 && dl_a !== 1'b1) wr_idle++;
        prev_wr_a = wr_a;
        prev_dl_a = dl_a;

        if (wr_b === 1'b1) begin
            wr_cyc_b.push_back(cyc);
            wr_addr_b.push_back(ia_b);
            wr_dout_b.push_back(id_b);
        end
        if (dl_b === 1'b1 && prev_dl_b !== 1'b1) rise_b.push_back(cyc);
        if (dl_b === 1'b0 && prev_dl_b === 1'b1) fall_b.push_back(cyc);
        if (done_b === 1'b1) done_cyc_b.push_back(cyc);
        if (idx_b !== ((dl_b === 1'b1) ? IDX_B : 8'h00)) idx_bad++;
        if (wr_b === 1'b1 && prev_wr_b === 1'b1) dbl_wr++;
        if (wr_b === 1'b1 && dl_b !== 1'b1) wr_idle++;
        prev_wr_b = wr_b;
        prev_dl_b = dl_b;
    end

    task automatic clear_a();
        wr_cyc_a.delete(); wr_addr_a.delete(); wr_dout_a.delete();
        rise_a.delete(); fall_a.delete(); done_cyc_a.delete();
    endtask

    // Cycle in which the GAP that starts with strobe cycle s is released (counter
    // at zero and hold low in that cycle).
    function automatic int gap_release(input int s);
        int c = s + GAP_A - 1;
        while (hold_log[c % LOGN] && c < s + 2000) c++;
        return c;
    endfunction

    // Starts instance A, drives hold for cycles [e+hold_off, e+hold_off+hold_len)
    // and an extra start pulse in cycle e+pulse_off, then waits for done.
    task automatic launch_a(input int hold_off, input int hold_len, input int pulse_off,
                            output int e, input string tag);
        bit ok = 1'b0;
        clear_a();
        @(negedge clk);
        start_a = 1'b1;
        e = cyc + 1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
            start_a = (n == pulse_off);
            hold_a  = (n >= hold_off && n < hold_off + hold_len);
        end
        start_a = 1'b0;
        hold_a  = 1'b0;
        @(negedge clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s done_timeout: done never seen within 600 cycles", tag);
        end
    endtask

    task automatic compare_a(input int e, input string tag);
        int s = e + DLY_A + 2;
        int f;
        checks++;
        if (wr_cyc_a.size() !== LEN_A) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d want %0d", tag, wr_cyc_a.size(), LEN_A);
        end
        for (int k = 0; k < LEN_A; k++) begin
            if (k > 0) s = gap_release(s) + 3;
            if (k < wr_cyc_a.size()) begin
                checks++;
                if (wr_cyc_a[k] !== s) begin
                    errors++;
                    $display("FAIL %s strobe%0d_time: got %0d want %0d", tag, k, wr_cyc_a[k] - e, s - e);
                end
                checks++;
                if (wr_addr_a[k] !== AW_A'(k) || wr_dout_a[k] !== img_a[k]) begin
                    errors++;
                    $display("FAIL %s strobe%0d_data: got (%0h,%02h) want (%0h,%02h)",
                             tag, k, wr_addr_a[k], wr_dout_a[k], k, img_a[k]);
                end
            end
        end
        f = gap_release(s) + 1;
        checks++;
        if (rise_a.size() !== 1 || rise_a[0] !== e) begin
            errors++;
            $display("FAIL %s dl_rise: got %0d edges first %0d want 1 at %0d", tag, rise_a.size(),
                     (rise_a.size() > 0) ? rise_a[0] : -1, e);
        end
        checks++;
        if (fall_a.size() !== 1 || fall_a[0] !== f) begin
            errors++;
            $display("FAIL %s dl_fall: got %0d edges first %0d want 1 at %0d", tag, fall_a.size(),
                     (fall_a.size() > 0) ? fall_a[0] : -1, f);
        end
        checks++;
        if (done_cyc_a.size() !== 1 || done_cyc_a[0] !== f) begin
            errors++;
            $display("FAIL %s done_pulse: got %0d cycles first %0d want 1 at %0d", tag,
                     done_cyc_a.size(), (done_cyc_a.size() > 0) ? done_cyc_a[0] : -1, f);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1; hold_a = 1'b0; hold_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({dl_a, wr_a, done_a, idx_a, ia_a, id_a, rom_addr_a,
                 dl_b, wr_b, done_b, idx_b, ia_b, id_b, rom_addr_b} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: cycle %0d dl_a=%b wr_a=%b done_a=%b dl_b=%b some output nonzero",
                         i, dl_a, wr_a, done_a, dl_b);
            end
        end
        rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
        clear_a();
        repeat (5) @(negedge clk);
        checks++;
        if (dl_a !== 1'b0 || dl_b !== 1'b0 || wr_cyc_a.size() !== 0) begin
            errors++;
            $display("FAIL reset_idle: dl_a=%b dl_b=%b strobes=%0d want 0 0 0", dl_a, dl_b, wr_cyc_a.size());
        end
    endtask

    task automatic test_basic();
        int e;
        img_a[0] = 8'hA5; img_a[1] = 8'h5A; img_a[2] = 8'h00; img_a[3] = 8'hFF;
        launch_a(0, 0, -1, e, "basic");
        compare_a(e, "basic");
        checks++;
        if (wr_cyc_a.size() > 0 && wr_cyc_a[0] - e !== 18) begin
            errors++;
            $display("FAIL basic_first_latency: got %0d want 18", wr_cyc_a[0] - e);
        end
        checks++;
        if (ia_a !== AW_A'(3) || id_a !== 8'hFF) begin
            errors++;
            $display("FAIL basic_held_outputs: got (%0h,%02h) want (3,ff)", ia_a, id_a);
        end
    endtask

    task automatic test_hold();
        int e;
        foreach (img_a[i]) img_a[i] = 8'($urandom);
        launch_a(29, 20, -1, e, "hold_gap");
        compare_a(e, "hold_gap");
        checks++;
        if (wr_cyc_a.size() > 2 && wr_cyc_a[2] - wr_cyc_a[1] !== 25) begin
            errors++;
            $display("FAIL hold_gap_spacing: got %0d want 25", wr_cyc_a[2] - wr_cyc_a[1]);
        end
        launch_a(2, 10, -1, e, "hold_delay");
        compare_a(e, "hold_delay");
        checks++;
        if (fall_a.size() > 0 && fall_a[0] - e !== 52) begin
            errors++;
            $display("FAIL hold_delay_length: got %0d want 52", fall_a[0] - e);
        end
    endtask

    task automatic test_random();
        int e;
        for (int r = 0; r < 4; r++) begin
            foreach (img_a[i]) img_a[i] = 8'($urandom);
            launch_a(int'($urandom_range(0, 60)), int'($urandom_range(0, 12)), -1, e, "random");
            compare_a(e, "random");
        end
    endtask

    task automatic test_restart_ignored();
        int e;
        launch_a(0, 0, 30, e, "restart_mid");
        compare_a(e, "restart_mid");
        launch_a(0, 0, 5, e, "restart_delay");
        compare_a(e, "restart_delay");
    endtask

    task automatic test_back_to_back();
        int  e, f;
        bit  ok = 1'b0;
        clear_a();
        @(negedge clk);
        start_a = 1'b1;
        e = cyc + 1;
        f = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                f = cyc;
                break;
            end
        end
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        checks++;
        if (!ok || f < 0) begin
            errors++;
            $display("FAIL b2b_timeout: got first_done=%0d second=%0b want both", f, ok);
        end
        checks++;
        if (rise_a.size() !== 2 || fall_a.size() < 1 || rise_a[1] - fall_a[0] !== 1) begin
            errors++;
            $display("FAIL b2b_low_gap: got %0d rises want 2 with 1-cycle low", rise_a.size());
        end
        checks++;
        if (wr_cyc_a.size() !== 2 * LEN_A) begin
            errors++;
            $display("FAIL b2b_strobes: got %0d want %0d", wr_cyc_a.size(), 2 * LEN_A);
        end else if (wr_cyc_a[LEN_A] !== f + 1 + DLY_A + 2 || wr_addr_a[LEN_A] !== '0) begin
            errors++;
            $display("FAIL b2b_second_first: got t=%0d a=%0h want t=%0d a=0",
                     wr_cyc_a[LEN_A], wr_addr_a[LEN_A], f + 1 + DLY_A + 2);
        end
    endtask

    task automatic test_reset_abort();
        int e;
        clear_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 0; n < 200 && wr_cyc_a.size() < 2; n++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (dl_a !== 1'b0 || wr_cyc_a.size() !== 2) begin
            errors++;
            $display("FAIL abort_dl: got dl=%b strobes=%0d want 0 2", dl_a, wr_cyc_a.size());
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (done_cyc_a.size() !== 0 || dl_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses dl=%b want 0 0", done_cyc_a.size(), dl_a);
        end
        launch_a(0, 0, -1, e, "after_abort");
        compare_a(e, "after_abort");
    endtask

    task automatic test_small_aw();
        int  e, s;
        bit  ok = 1'b0;
        foreach (img_b[i]) img_b[i] = 8'($urandom);
        wr_cyc_b.delete(); wr_addr_b.delete(); wr_dout_b.delete();
        rise_b.delete(); fall_b.delete(); done_cyc_b.delete();
        @(negedge clk);
        start_b = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        start_b = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done_b === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        checks++;
        if (!ok || wr_cyc_b.size() !== LEN_B) begin
            errors++;
            $display("FAIL small_count: got done=%0b strobes=%0d want 1 %0d", ok, wr_cyc_b.size(), LEN_B);
        end
        for (int k = 0; k < LEN_B && k < wr_cyc_b.size(); k++) begin
            s = e + DLY_B + 2 + k * (2 + GAP_B);
            checks++;
            if (wr_cyc_b[k] !== s || wr_addr_b[k] !== AW_B'(k) || wr_dout_b[k] !== img_b[k]) begin
                errors++;
                $display("FAIL small_strobe%0d: got (t%0d,%0h,%02h) want (t%0d,%0h,%02h)", k,
                         wr_cyc_b[k] - e, wr_addr_b[k], wr_dout_b[k], s - e, k, img_b[k]);
            end
        end
        checks++;
        if (ia_b !== 3'd7 || done_cyc_b.size() !== 1 || fall_b.size() !== 1 ||
            fall_b[0] - e !== DLY_B + LEN_B * (2 + GAP_B)) begin
            errors++;
            $display("FAIL small_end: got last=%0h dones=%0d falls=%0d want 7 1 1 at %0d",
                     ia_b, done_cyc_b.size(), fall_b.size(), DLY_B + LEN_B * (2 + GAP_B));
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (idx_bad !== 0 || dbl_wr !== 0 || wr_idle !== 0) begin
            errors++;
            $display("FAIL invariants: got idx_bad=%0d dbl_wr=%0d wr_idle=%0d want 0 0 0",
                     idx_bad, dbl_wr, wr_idle);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_random();
        test_restart_ignored();
        test_back_to_back();
        test_reset_abort();
        test_small_aw();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
